vdp_host_bus_if: RTL and testbench

- Parametrised host-CPU bus front end for the VDP core. Sits between the board pins (csw_n, csr_n, mode, cd) and the VDP REQ/WRT/ADR/DBO/DBI/ACK interface.
- Successor to the single-slot latch. Adds configurable glitch filtering, a write FIFO that absorbs back-to-back writes, and full REQ/ACK handshaking with timeout.
- Adds read ordering behind pending writes, plus sticky error flags.

---
 rtl/vdp_bus_pkg.sv | 22 ++
 rtl/vdp_host_bus_if_if.sv | 19 +
 rtl/bus_pin_filter.sv | 49 ++++
 rtl/vdp_host_bus_if.sv | 193 +++++++++++++++++++
 tb/tb_vdp_host_bus_if.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_bus_pkg.sv
// rtl/vdp_bus_pkg.sv - shared types and default constants for the VDP host bus front end
package vdp_bus_pkg;

  localparam int DEF_ADDR_W      = 2;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_FILTER_LEN  = 3;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2
  } bus_state_t;

  // One host write as seen by the VDP core, at the default bus widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] adr;
    logic [DEF_DATA_W-1:0] dbo;
  } bus_entry_t;

endpackage

// File: rtl/vdp_host_bus_if_if.sv
// rtl/vdp_host_bus_if_if.sv - REQ/ACK request bus between the host front end and the VDP core
interface vdp_host_bus_if_if
  import vdp_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic              wrt;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dbo;
  logic              ack;
  logic [DATA_W-1:0] dbi;

  modport master (output req, wrt, adr, dbo, input ack, dbi);
  modport slave  (input req, wrt, adr, dbo, output ack, dbi);

endinterface

// File: rtl/bus_pin_filter.sv
// rtl/bus_pin_filter.sv - two-flop synchroniser plus N-sample agreement filter for an active-low strobe
module bus_pin_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_n,
  output logic level,
  output logic fell
);

  localparam int CNT_W = 4;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] agree_cnt;

  // bring the asynchronous pin into the clk domain; idle level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin_n;
      sync2 <= sync1;
    end
  end

  // accept a new level only after FILTER_LEN consecutive differing samples; fell pulses with the change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level     <= 1'b1;
      fell      <= 1'b0;
      agree_cnt <= '0;
    end else begin
      fell <= 1'b0;
      if (sync2 == level) begin
        agree_cnt <= '0;
      end else if (agree_cnt == CNT_W'(FILTER_LEN - 1)) begin
        level     <= sync2;
        fell      <= ~sync2;
        agree_cnt <= '0;
      end else begin
        agree_cnt <= agree_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vdp_host_bus_if.sv
// rtl/vdp_host_bus_if.sv - host CPU bus front end: strobe filtering, write FIFO, ordered REQ/ACK with timeout
module vdp_host_bus_if
  import vdp_bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              csw_n,
  input  logic              csr_n,
  input  logic [ADDR_W-1:0] mode,
  input  logic [DATA_W-1:0] cd_in,
  output logic [DATA_W-1:0] cd_out,
  output logic              cd_oe,
  vdp_host_bus_if_if.master vdp,
  output logic              fifo_full,
  output logic              overflow,
  output logic              timeout,
  output logic              collision
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dbo;
  } fifo_entry_t;

  logic [ADDR_W-1:0] mode_s1, mode_s2;
  logic [DATA_W-1:0] cd_s1, cd_s2;

  logic wr_level, wr_fell;
  logic rd_level, rd_fell;
  logic both_low, wr_edge, rd_edge;

  fifo_entry_t       fifo_mem [FIFO_DEPTH];
  fifo_entry_t       fifo_head;
  logic [PTR_W:0]    wr_ptr, rd_ptr, fifo_count;
  logic              fifo_empty, push_ok, pop;

  logic              rd_pending;
  logic [ADDR_W-1:0] rd_adr;

  bus_state_t        state_q, state_d;
  logic [TMO_W-1:0]  wait_cnt;
  logic              in_req, tmo_hit, done, abandon, rd_done;

  bus_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filter (
    .clk   (clk),
    .reset (reset),
    .pin_n (csw_n),
    .level (wr_level),
    .fell  (wr_fell)
  );

  bus_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filter (
    .clk   (clk),
    .reset (reset),
    .pin_n (csr_n),
    .level (rd_level),
    .fell  (rd_fell)
  );

  // address and data are only sampled at a filtered strobe edge, so a plain two-flop sync suffices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_s1 <= '0;
      mode_s2 <= '0;
      cd_s1   <= '0;
      cd_s2   <= '0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      cd_s1   <= cd_in;
      cd_s2   <= cd_s1;
    end
  end

  assign both_low   = ~wr_level & ~rd_level;
  assign wr_edge    = wr_fell & ~both_low;
  assign rd_edge    = rd_fell & ~both_low;
  assign cd_oe      = ~rd_level;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign push_ok    = wr_edge & ~fifo_full;

  assign in_req     = (state_q != IDLE);
  assign tmo_hit    = in_req && (wait_cnt == TMO_W'(ACK_TIMEOUT - 1));
  assign done       = in_req && (vdp.ack || tmo_hit);
  assign abandon    = tmo_hit && !vdp.ack;
  assign pop        = (state_q == WR_REQ) && done;
  assign rd_done    = (state_q == RD_REQ) && done;

  // write FIFO pointers; fullness is judged before a same-cycle pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  // FIFO storage carries no reset; validity is tracked entirely by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[PTR_W-1:0]] <= {mode_s2, cd_s2};
  end

  // pending read, read data return and the sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      rd_adr     <= '0;
      cd_out     <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
      collision  <= 1'b0;
    end else begin
      if (rd_done) rd_pending <= 1'b0;
      if (rd_edge && (!rd_pending || rd_done)) begin
        rd_pending <= 1'b1;
        rd_adr     <= mode_s2;
      end
      if ((state_q == RD_REQ) && vdp.ack) cd_out <= vdp.dbi;
      if (wr_edge && fifo_full) overflow  <= 1'b1;
      if (abandon)              timeout   <= 1'b1;
      if (both_low)             collision <= 1'b1;
    end
  end

  // request age counter, restarted for every transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!in_req || done) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TMO_W'(1);
    end
  end

  // sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // writes always drain before a read, and every transaction returns through IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty)     state_d = WR_REQ;
        else if (rd_pending) state_d = RD_REQ;
      end
      WR_REQ, RD_REQ: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // request outputs are driven only while a request is open
  always_comb begin
    vdp.req = 1'b0;
    vdp.wrt = 1'b0;
    vdp.adr = '0;
    vdp.dbo = '0;
    case (state_q)
      WR_REQ: begin
        vdp.req = 1'b1;
        vdp.wrt = 1'b1;
        vdp.adr = fifo_head.adr;
        vdp.dbo = fifo_head.dbo;
      end
      RD_REQ: begin
        vdp.req = 1'b1;
        vdp.adr = rd_adr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vdp_host_bus_if.sv
// tb/tb_vdp_host_bus_if.sv - randomized self-checking bench with a transaction-order reference model
`timescale 1ns/1ps
module tb_vdp_host_bus_if;
  import vdp_bus_pkg::*;

  localparam int FILTER_LEN = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int TMO_SHORT  = 16;

  typedef struct {
    bit         wrt;
    bus_entry_t e;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       csw_n, csr_n;
  logic [1:0] mode;
  logic [7:0] cd_in;

  logic [7:0] cd_out, cd_out_t;
  logic       cd_oe, cd_oe_t;
  logic       fifo_full, overflow, timeout, collision;
  logic       fifo_full_t, overflow_t, timeout_t, collision_t;

  vdp_host_bus_if_if #(.ADDR_W(2), .DATA_W(8)) vdp_a ();
  vdp_host_bus_if_if #(.ADDR_W(2), .DATA_W(8)) vdp_b ();

  vdp_host_bus_if #(
    .ADDR_W(2), .DATA_W(8), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .csw_n(csw_n), .csr_n(csr_n), .mode(mode), .cd_in(cd_in),
    .cd_out(cd_out), .cd_oe(cd_oe), .vdp(vdp_a), .fifo_full(fifo_full),
    .overflow(overflow), .timeout(timeout), .collision(collision)
  );

  vdp_host_bus_if #(
    .ADDR_W(2), .DATA_W(8), .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(TMO_SHORT)
  ) dut_t (
    .clk(clk), .reset(reset), .csw_n(csw_n), .csr_n(csr_n), .mode(mode), .cd_in(cd_in),
    .cd_out(cd_out_t), .cd_oe(cd_oe_t), .vdp(vdp_b), .fifo_full(fifo_full_t),
    .overflow(overflow_t), .timeout(timeout_t), .collision(collision_t)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  txn_t       exp_q[$];
  int         txn_seen = 0;
  int         rd_acks  = 0;
  bit         ack_en;
  int         ack_delay;
  logic [7:0] rd_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // VDP core model: checks each new request against the expected order and acks after ack_delay
  initial begin : core_model
    int   wait_cnt;
    bit   in_txn;
    txn_t t;
    wait_cnt = 0;
    in_txn   = 0;
    vdp_a.ack = 1'b0;
    vdp_a.dbi = '0;
    vdp_b.ack = 1'b0;
    vdp_b.dbi = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        vdp_a.ack = 1'b0;
        in_txn    = 0;
        wait_cnt  = 0;
      end else if (vdp_a.ack) begin
        vdp_a.ack = 1'b0;
        check("req_drop_after_ack", vdp_a.req, 1'b0);
      end else if (vdp_a.req) begin
        if (!in_txn) begin
          in_txn   = 1;
          wait_cnt = 0;
          txn_seen++;
          check("txn_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            check("txn_wrt", vdp_a.wrt, t.wrt);
            check("txn_adr", vdp_a.adr, t.e.adr);
            if (t.wrt) check("txn_dbo", vdp_a.dbo, t.e.dbo);
          end
        end
        if (ack_en && wait_cnt >= ack_delay) begin
          vdp_a.ack = 1'b1;
          if (!vdp_a.wrt) begin
            vdp_a.dbi = rd_data;
            rd_acks++;
          end
          in_txn = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic expect_txn(input bit wrt, input logic [1:0] adr, input logic [7:0] dbo);
    txn_t t;
    t.wrt   = wrt;
    t.e.adr = adr;
    t.e.dbo = dbo;
    exp_q.push_back(t);
  endtask

  // A write is accepted when the strobe stays low long enough to pass the filter and the FIFO has room
  task automatic host_write(input logic [1:0] m, input logic [7:0] d, input int low_cycles,
                            input int hi_cycles, input bit room);
    if (low_cycles >= FILTER_LEN && room) expect_txn(1'b1, m, d);
    mode  = m;
    cd_in = d;
    csw_n = 1'b0;
    repeat (low_cycles) @(negedge clk);
    csw_n = 1'b1;
    repeat (hi_cycles) @(negedge clk);
  endtask

  task automatic host_read(input logic [1:0] m, input logic [7:0] d);
    int start;
    int n;
    expect_txn(1'b0, m, 8'h00);
    rd_data = d;
    start   = rd_acks;
    check("cd_oe_before_read", cd_oe, 1'b0);
    mode  = m;
    csr_n = 1'b0;
    n = 0;
    while (rd_acks == start && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rd_acked", rd_acks - start, 1);
    @(negedge clk);
    check("rd_cd_out", cd_out, d);
    check("rd_cd_oe", cd_oe, 1'b1);
    csr_n = 1'b1;
    repeat (FILTER_LEN + 3) @(negedge clk);
    check("cd_oe_release", cd_oe, 1'b0);
    check("cd_out_hold", cd_out, d);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || vdp_a.req) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: run did not complete, %0d comparisons so far", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int seen;
    int cnt;
    int op;
    int low;
    reset     = 1'b1;
    csw_n     = 1'b1;
    csr_n     = 1'b1;
    mode      = 2'd0;
    cd_in     = 8'h00;
    ack_en    = 1'b1;
    ack_delay = 2;
    rd_data   = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_bus_outputs", {cd_out, cd_oe, vdp_a.req, vdp_a.wrt, vdp_a.adr, vdp_a.dbo}, 0);
    check("rst_flags", {fifo_full, overflow, timeout, collision}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single write: pin low first sampled at edge 0, req expected at edge FILTER_LEN+3
    expect_txn(1'b1, 2'b01, 8'hA5);
    mode  = 2'b01;
    cd_in = 8'hA5;
    csw_n = 1'b0;
    repeat (FILTER_LEN + 3) @(negedge clk);
    check("wr_req_before_edge6", vdp_a.req, 1'b0);
    @(negedge clk);
    check("wr_req_at_edge6", vdp_a.req, 1'b1);
    check("wr_wrt_at_edge6", vdp_a.wrt, 1'b1);
    check("wr_adr_at_edge6", vdp_a.adr, 2'b01);
    check("wr_dbo_at_edge6", vdp_a.dbo, 8'hA5);
    repeat (3) @(negedge clk);
    csw_n = 1'b1;
    repeat (4) @(negedge clk);
    wait_drain("single_write_drain");

    // back-to-back writes with slow acks, then a read that must wait for them
    ack_delay = 20;
    for (int i = 0; i < 3; i++) host_write(2'($urandom), 8'($urandom), 8, 4, 1'b1);
    host_read(2'($urandom), 8'h3C);
    wait_drain("b2b_drain");

    // randomized mix of writes, short glitches and reads
    for (int i = 0; i < 16; i++) begin
      ack_delay = $urandom_range(0, 6);
      op = $urandom_range(0, 3);
      if (op == 0) begin
        host_read(2'($urandom), 8'($urandom));
      end else begin
        low = $urandom_range(1, 10);
        host_write(2'($urandom), 8'($urandom), low, 4, 1'b1);
      end
    end
    wait_drain("random_drain");
    check("random_no_overflow", overflow, 1'b0);
    check("random_no_timeout", timeout, 1'b0);
    check("random_no_collision", collision, 1'b0);

    // glitch shorter than the filter: no push, no request
    seen = txn_seen;
    host_write(2'd2, 8'h5A, FILTER_LEN - 1, 4, 1'b1);
    repeat (15) @(negedge clk);
    check("glitch_no_txn", txn_seen - seen, 0);
    check("glitch_req_low", vdp_a.req, 1'b0);

    // overflow: ack withheld, one more write than the FIFO holds
    ack_en = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      host_write(2'(i), 8'(8'h10 + i), 8, 4, i < FIFO_DEPTH);
      check($sformatf("ovf_full_%0d", i), fifo_full, i >= FIFO_DEPTH - 1);
      check($sformatf("ovf_flag_%0d", i), overflow, i >= FIFO_DEPTH);
    end
    ack_delay = 1;
    ack_en    = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_full_cleared", fifo_full, 1'b0);

    // synchronous-looking reset pulse clears every sticky flag
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_flags", {fifo_full, overflow, timeout, collision}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // timeout on the short-timeout instance whose core never acks
    fork
      host_write(2'd3, 8'hC3, 8, 4, 1'b1);
      begin
        cnt = 0;
        while (!vdp_b.req && cnt < 40) begin
          @(negedge clk);
          cnt++;
        end
        check("tmo_req_seen", vdp_b.req, 1'b1);
        cnt = 0;
        while (vdp_b.req && cnt < 100) begin
          @(negedge clk);
          cnt++;
        end
        check("tmo_req_cycles", cnt, TMO_SHORT);
        check("tmo_flag", timeout_t, 1'b1);
      end
    join
    repeat (10) @(negedge clk);
    check("tmo_no_retry", vdp_b.req, 1'b0);
    check("tmo_fifo_not_full", fifo_full_t, 1'b0);
    wait_drain("tmo_side_drain");
    check("tmo_main_flag_clear", timeout, 1'b0);

    // collision: both strobes low together are ignored
    seen  = txn_seen;
    csw_n = 1'b0;
    csr_n = 1'b0;
    repeat (10) @(negedge clk);
    check("coll_flag", collision, 1'b1);
    check("coll_req_low", vdp_a.req, 1'b0);
    csw_n = 1'b1;
    csr_n = 1'b1;
    repeat (10) @(negedge clk);
    check("coll_no_txn", txn_seen - seen, 0);

    // asynchronous reset while a read request is open
    ack_en = 1'b0;
    expect_txn(1'b0, 2'd2, 8'h00);
    mode  = 2'd2;
    csr_n = 1'b0;
    cnt = 0;
    while (!vdp_a.req && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("rdreq_open", vdp_a.req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", vdp_a.req, 1'b0);
    check("async_rst_flags", {overflow, timeout, collision}, 0);
    check("async_rst_cd_oe", cd_oe, 1'b0);
    csr_n = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    ack_en = 1'b1;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    host_write(2'd1, 8'h77, 8, 4, 1'b1);
    wait_drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
